// File: rtl/down_fifo_pkg.sv
// Shared types and width helpers for the downstream FIFO arbiter.
package down_fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int unsigned PKT_CNT_W = 16;

  // Counter/index width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/down_fifo_arbiter_if.sv
// Requester-side streams plus the shared FIFO write port, seen from the arbiter.
interface down_fifo_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] dat_i;
  logic [NUM_REQ-1:0]        valid_i;
  logic [NUM_REQ-1:0]        last_i;
  logic [NUM_REQ-1:0]        ready_o;
  logic [DATA_W-1:0]         fifo_dat_o;
  logic                      fifo_wr_o;
  logic                      fifo_full_i;
  logic [NUM_REQ-1:0]        grant_o;

  modport slave (
    input  req_i, dat_i, valid_i, last_i, fifo_full_i,
    output ready_o, fifo_dat_o, fifo_wr_o, grant_o
  );

  modport master (
    output req_i, dat_i, valid_i, last_i, fifo_full_i,
    input  ready_o, fifo_dat_o, fifo_wr_o, grant_o
  );

endinterface

// File: rtl/down_fifo_rr_pick.sv
// Combinational round-robin picker: first request at or above the pointer, with wrap.
module down_fifo_rr_pick
  import down_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = cnt_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               found_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!found_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/down_fifo_arbiter.sv
// Packet-granular round-robin arbiter feeding one shared downstream FIFO,
// with stall-timeout and over-length protection plus sticky status.
module down_fifo_arbiter
  import down_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_PKT = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  down_fifo_arbiter_if.slave   bus,
  output logic                 busy_o,
  output logic                 err_timeout_o,
  output logic                 err_overlen_o,
  input  logic                 clear_err_i,
  output logic [PKT_CNT_W-1:0] pkt_cnt_o
);

  localparam int unsigned PTR_W  = cnt_w(NUM_REQ);
  localparam int unsigned WCNT_W = cnt_w(MAX_PKT);
  localparam int unsigned TMR_W  = cnt_w(TIMEOUT);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [DATA_W-1:0]    fifo_dat_q, fifo_dat_d;
  logic                 fifo_wr_q, fifo_wr_d;
  logic                 busy_q, busy_d;
  logic                 err_to_q, err_to_d;
  logic                 err_ol_q, err_ol_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic                 pick_found;
  logic [NUM_REQ-1:0]   ready_c;
  logic [PTR_W-1:0]     gidx;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [DATA_W-1:0]    dat_g;
  logic                 valid_g;
  logic                 last_g;
  logic                 acc;
  logic                 new_to;
  logic                 new_ol;

  down_fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .found_o (pick_found)
  );

  // Granted-lane view; grant_q is zero outside XFER so ready stays low in IDLE.
  always_comb begin
    ready_c = grant_q & bus.valid_i & {NUM_REQ{~bus.fifo_full_i}};
    valid_g = |(grant_q & bus.valid_i);
    last_g  = |(grant_q & bus.last_i);
    acc     = |ready_c;
    gidx    = '0;
    dat_g   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        gidx = PTR_W'(k);
      end
      dat_g = dat_g | (bus.dat_i[k*DATA_W +: DATA_W] & {DATA_W{grant_q[k]}});
    end
    ptr_nxt = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    wcnt_d     = wcnt_q;
    tmr_d      = tmr_q;
    fifo_dat_d = fifo_dat_q;
    fifo_wr_d  = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    new_to     = 1'b0;
    new_ol     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_gnt;
          state_d = XFER;
          wcnt_d  = '0;
          tmr_d   = '0;
        end
      end
      XFER: begin
        if (acc) begin
          fifo_wr_d  = 1'b1;
          fifo_dat_d = dat_g;
          tmr_d      = '0;
          // A full-length packet without last is cut here; the rest re-arbitrates.
          if (last_g || (wcnt_q == WCNT_W'(MAX_PKT - 1))) begin
            new_ol    = ~last_g;
            pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
            ptr_d     = ptr_nxt;
            grant_d   = '0;
            state_d   = IDLE;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end else if (!valid_g) begin
          if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            new_to  = 1'b1;
            ptr_d   = ptr_nxt;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == XFER);
    err_to_d = new_to | (err_to_q & ~clear_err_i);
    err_ol_d = new_ol | (err_ol_q & ~clear_err_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      wcnt_q     <= '0;
      tmr_q      <= '0;
      fifo_dat_q <= '0;
      fifo_wr_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_ol_q   <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      wcnt_q     <= wcnt_d;
      tmr_q      <= tmr_d;
      fifo_dat_q <= fifo_dat_d;
      fifo_wr_q  <= fifo_wr_d;
      busy_q     <= busy_d;
      err_to_q   <= err_to_d;
      err_ol_q   <= err_ol_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign bus.ready_o    = ready_c;
  assign bus.grant_o    = grant_q;
  assign bus.fifo_dat_o = fifo_dat_q;
  assign bus.fifo_wr_o  = fifo_wr_q;
  assign busy_o         = busy_q;
  assign err_timeout_o  = err_to_q;
  assign err_overlen_o  = err_ol_q;
  assign pkt_cnt_o      = pkt_cnt_q;

endmodule

// File: tb/tb_down_fifo_arbiter.sv
// Self-checking bench for down_fifo_arbiter: queue-backed requesters and a FIFO-write scoreboard.
module tb_down_fifo_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned MP = 8;
  localparam int unsigned TO = 16;

  typedef struct {
    logic [31:0] dat;
    bit          last;
    bit          hold;
  } beat_t;

  typedef struct {
    int          req;
    int          len;
    logic [31:0] base;
    int          exp_pkt;
    logic [1:0]  exp_grant;
    bit          exp_ol;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic        err_to;
  logic        err_ol;
  logic        clear_err;
  logic [15:0] pkt_cnt;

  down_fifo_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) dif ();

  down_fifo_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .MAX_PKT (MP),
    .TIMEOUT (TO)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .bus           (dif),
    .busy_o        (busy),
    .err_timeout_o (err_to),
    .err_overlen_o (err_ol),
    .clear_err_i   (clear_err),
    .pkt_cnt_o     (pkt_cnt)
  );

  beat_t       src0[$];
  beat_t       src1[$];
  logic [31:0] exp_q[$];
  logic [1:0]  glog[$];
  int          gaps[$];
  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          wr_cnt, first_wr, last_wr, first_gcyc, gap;
  logic [1:0]  prev_grant = 2'b00;
  bit          acc0 = 1'b0;
  bit          acc1 = 1'b0;
  int          exp_pkt = 0;
  vec_t        vecs[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requester model: request while words are queued, valid unless a hold marker is at the head.
  task automatic drive();
    dif.req_i[0]      = (src0.size() > 0);
    dif.valid_i[0]    = (src0.size() > 0) && !src0[0].hold;
    dif.last_i[0]     = (src0.size() > 0) && src0[0].last;
    dif.dat_i[31:0]   = (src0.size() > 0) ? src0[0].dat : 32'h0;
    dif.req_i[1]      = (src1.size() > 0);
    dif.valid_i[1]    = (src1.size() > 0) && !src1[0].hold;
    dif.last_i[1]     = (src1.size() > 0) && src1[0].last;
    dif.dat_i[63:32]  = (src1.size() > 0) ? src1[0].dat : 32'h0;
  endtask

  always begin
    drive();
    @(posedge clk);
    #2;
    if (acc0 && src0.size() > 0) void'(src0.pop_front());
    if (acc1 && src1.size() > 0) void'(src1.pop_front());
    acc0 = 1'b0;
    acc1 = 1'b0;
  end

  // Monitor: handshake capture, scoreboard on FIFO writes, grant log with idle gaps.
  always @(negedge clk) begin
    acc0 = dif.ready_o[0] & dif.valid_i[0];
    acc1 = dif.ready_o[1] & dif.valid_i[1];
    if (rst_n) begin
      if (dif.fifo_wr_o) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL fifo_wr: got write %h expected no write (cycle %0d)", dif.fifo_dat_o, cyc);
        end else begin
          chk("fifo_dat", dif.fifo_dat_o, exp_q.pop_front());
        end
      end
      if (dif.grant_o != 2'b00 && prev_grant == 2'b00) begin
        glog.push_back(dif.grant_o);
        gaps.push_back(gap);
        if (first_gcyc < 0) first_gcyc = cyc;
      end
      if (dif.grant_o == 2'b00) gap++;
      else gap = 0;
      prev_grant = dif.grant_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_cnt = 0; first_wr = -1; last_wr = -1; first_gcyc = -1; gap = 0;
    glog.delete();
    gaps.delete();
  endtask

  task automatic load(input int k, input logic [31:0] base, input int n, input bit last_end, input bit push_exp);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.dat  = base + 32'(i);
      b.last = last_end && (i == n - 1);
      b.hold = 1'b0;
      if (k == 0) src0.push_back(b);
      else        src1.push_back(b);
      if (push_exp) exp_q.push_back(b.dat);
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && busy == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " idle reached"}, 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_grant(input string nm, input logic [1:0] m, input int budget);
    int n = 0;
    while (dif.grant_o !== m && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(dif.grant_o), 32'(m));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " grant"},    32'(dif.grant_o),    32'd0);
    chk({nm, " ready"},    32'(dif.ready_o),    32'd0);
    chk({nm, " fifo_wr"},  32'(dif.fifo_wr_o),  32'd0);
    chk({nm, " fifo_dat"}, dif.fifo_dat_o,      32'd0);
    chk({nm, " busy"},     32'(busy),           32'd0);
    chk({nm, " err_to"},   32'(err_to),         32'd0);
    chk({nm, " err_ol"},   32'(err_ol),         32'd0);
    chk({nm, " pkt_cnt"},  32'(pkt_cnt),        32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 4,       32'h11, 1, 2'b01, 1'b0};
    vecs[1] = '{1, 3,       32'h20, 2, 2'b10, 1'b0};
    vecs[2] = '{0, 1,       32'h30, 3, 2'b01, 1'b0};
    vecs[3] = '{1, int'(MP), 32'h40, 4, 2'b10, 1'b0};

    rst_n            = 1'b0;
    clear_err        = 1'b0;
    dif.fifo_full_i  = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    tick(1);
    rst_n = 1'b1;

    // Single packets, one per vector
    for (int v = 0; v < 4; v++) begin
      tick(1);
      clear_logs();
      load(vecs[v].req, vecs[v].base, vecs[v].len, 1'b1, 1'b1);
      wait_idle("vec", 100);
      chk("vec pkt_cnt",   32'(pkt_cnt), 32'(vecs[v].exp_pkt));
      chk("vec grant",     32'((glog.size() > 0) ? glog[0] : 2'b00), 32'(vecs[v].exp_grant));
      chk("vec wr_cnt",    32'(wr_cnt), 32'(vecs[v].len));
      chk("vec wr_span",   32'(last_wr - first_wr), 32'(vecs[v].len - 1));
      chk("vec latency",   32'(first_wr - first_gcyc), 32'd1);
      chk("vec err_ol",    32'(err_ol), 32'(vecs[v].exp_ol));
      chk("vec grant_end", 32'(dif.grant_o), 32'd0);
      chk("vec sb empty",  32'(exp_q.size()), 32'd0);
    end
    exp_pkt = 4;

    // Two requesters contending: strict alternation with one idle cycle between packets
    tick(1);
    clear_logs();
    load(0, 32'hA0, 3, 1'b1, 1'b1);
    load(1, 32'hB0, 3, 1'b1, 1'b1);
    load(0, 32'hA3, 3, 1'b1, 1'b1);
    load(1, 32'hB3, 3, 1'b1, 1'b1);
    wait_idle("alt", 200);
    exp_pkt += 4;
    chk("alt pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
    for (int i = 0; i < 4; i++) begin
      chk("alt grant", 32'((glog.size() > i) ? glog[i] : 2'b00), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) chk("alt gap", (gaps.size() > i) ? 32'(gaps[i]) : 32'hFFFF, 32'd1);
    end
    chk("alt sb empty", 32'(exp_q.size()), 32'd0);

    // FIFO full mid-packet for longer than the stall limit
    tick(1);
    load(0, 32'h50, int'(MP), 1'b1, 1'b1);
    wait_grant("full grant", 2'b01, 20);
    tick(2);
    dif.fifo_full_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("full ready", 32'(dif.ready_o), 32'd0);
      if (i > 0) chk("full fifo_wr", 32'(dif.fifo_wr_o), 32'd0);
    end
    tick(1);
    dif.fifo_full_i = 1'b0;
    wait_idle("full", 100);
    exp_pkt += 1;
    chk("full err_to",   32'(err_to), 32'd0);
    chk("full pkt_cnt",  32'(pkt_cnt), 32'(exp_pkt));
    chk("full sb empty", 32'(exp_q.size()), 32'd0);

    // Stalled requester: timeout aborts, grant passes to the other requester
    begin
      beat_t hb;
      int    n;
      tick(1);
      load(0, 32'h60, 2, 1'b0, 1'b1);
      hb.dat = 32'h0; hb.last = 1'b0; hb.hold = 1'b1;
      src0.push_back(hb);
      load(0, 32'h62, 3, 1'b1, 1'b0);
      wait_grant("to grant0", 2'b01, 20);
      tick(1);
      load(1, 32'h70, 2, 1'b1, 1'b1);
      n = 0;
      while (!(src0.size() > 0 && src0[0].hold) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("to stall start", 32'(n < 20), 32'd1);
      repeat (TO - 3) @(negedge clk);
      chk("to early err", 32'(err_to), 32'd0);
      n = 0;
      while (err_to !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk("to err_to", 32'(err_to), 32'd1);
      src0.delete();
      chk("to pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
      wait_grant("to grant1", 2'b10, 5);
      wait_idle("to", 50);
      exp_pkt += 1;
      chk("to pkt_cnt after", 32'(pkt_cnt), 32'(exp_pkt));
      chk("to sb empty", 32'(exp_q.size()), 32'd0);
      tick(1);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      @(negedge clk);
      chk("to cleared", 32'(err_to), 32'd0);
    end

    // Over-length packet: cut at MAX_PKT words, remainder goes as a new packet
    tick(1);
    clear_logs();
    chk("ol before", 32'(err_ol), 32'd0);
    load(0, 32'h80, int'(MP) + 2, 1'b1, 1'b1);
    wait_idle("ol", 100);
    exp_pkt += 2;
    chk("ol err_ol",    32'(err_ol), 32'd1);
    chk("ol pkt_cnt",   32'(pkt_cnt), 32'(exp_pkt));
    chk("ol grants",    32'(glog.size()), 32'd2);
    chk("ol wr_cnt",    32'(wr_cnt), 32'(MP + 2));
    chk("ol sb empty",  32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-packet, then pointer restarts at requester 0
    tick(1);
    load(1, 32'h90, 6, 1'b1, 1'b1);
    wait_grant("rst grant", 2'b10, 20);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    src0.delete();
    src1.delete();
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_logs();
    load(0, 32'hC0, 1, 1'b1, 1'b1);
    load(1, 32'hD0, 1, 1'b1, 1'b1);
    wait_idle("post rst", 50);
    chk("post rst first grant", 32'((glog.size() > 0) ? glog[0] : 2'b00), 32'd1);
    chk("post rst pkt_cnt", 32'(pkt_cnt), 32'd2);
    chk("post rst sb empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/down_fifo_arbiter.md
# down_fifo_arbiter

Packet-granular round-robin arbiter sharing the single downstream (Aurora-side) data FIFO between NUM_REQ streaming requesters. It grants one requester at a time and forwards that requester's packet word-by-word into the FIFO write port, honouring FIFO full. It guards the shared FIFO against a stalled or runaway requester with a stall timeout and a maximum packet length. Sticky error flags and a packet counter are exposed for the ILA/status path.

## Interface
- NUM_REQ, 2: number of requesters (2..4).
- DATA_W, 32: word width.
- MAX_PKT, 256: maximum words per packet; power of two; up to 65536.
- TIMEOUT, 1024: mid-packet stall limit in cycles; power of two.
- clk_i  in  1  single clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQ  per-requester packet request; level, held until the packet starts.
- dat_i  in  NUM_REQ*DATA_W  per-requester data; requester k occupies bits [k*DATA_W +: DATA_W].
- valid_i  in  NUM_REQ  per-requester word valid.
- last_i  in  NUM_REQ  per-requester last word of packet, qualified by valid_i.
- ready_o  out  NUM_REQ  per-requester word accept.
- fifo_dat_o  out  DATA_W  FIFO write data, registered.
- fifo_wr_o  out  1  FIFO write enable, registered.
- fifo_full_i  in  1  FIFO programmable-full; asserts with at least 2 free entries.
- grant_o  out  NUM_REQ  one-hot current grant, registered.
- busy_o  out  1  high outside IDLE.
- err_timeout_o  out  1  sticky stall-timeout flag.
- err_overlen_o  out  1  sticky over-length flag.
- clear_err_i  in  1  clears both sticky flags.
- pkt_cnt_o  out  16  completed-packet counter; wraps.

## Operation
- Reset values: grant_o 0, ready_o 0, fifo_wr_o 0, fifo_dat_o 0, busy_o 0, both error flags 0, pkt_cnt_o 0, priority pointer 0, state IDLE.
- IDLE: the arbiter picks the first asserted req_i, searching from the priority pointer upward with wrap. If one is found, it loads grant_o and enters XFER. With no requests it stays in IDLE.
- XFER: ready_o[g] = valid_i[g] & ~fifo_full_i; all other ready_o bits are 0. A beat is accepted when valid_i[g] & ready_o[g]. The beat registers into fifo_dat_o with fifo_wr_o = 1 on the next edge.
- Packet end on an accepted beat with last_i[g]:
  - pkt_cnt_o increments.
  - The pointer moves to (g+1) mod NUM_REQ.
  - grant_o clears and the state returns to IDLE.
- Word counter: counts accepted beats in the packet. An accepted beat without last_i at count MAX_PKT-1 ends the packet as if last, sets err_overlen_o and increments pkt_cnt_o. The requester's remaining words must re-arbitrate as a new packet.
- Stall timer:
  - Counts XFER cycles with valid_i[g] = 0.
  - Clears on any accepted beat.
  - Does not count cycles blocked only by fifo_full_i.
  - On reaching TIMEOUT-1 the packet aborts: err_timeout_o sets, grant drops, state returns to IDLE, pointer advances past g, pkt_cnt_o is not incremented. Words already written stay in the FIFO.
- Sticky flags: clear_err_i clears them. If clear_err_i coincides with a new error, the error wins (flag stays 1).
- Requester drops req_i while granted: ignored; only last, over-length or timeout ends a grant.
- fifo_full_i asserted: ready_o goes low in the same cycle. The 2-entry margin absorbs the registered write already in flight.

## Timing
- req_i high in IDLE at edge N: grant_o high after edge N; the first beat can be accepted in cycle N+1.
- Accepted beat at edge M: fifo_wr_o/fifo_dat_o valid after edge M, i.e. one cycle latency. Full throughput is one word per cycle while not full.
- Last beat at edge M: grant_o low and busy_o low after edge M. The next grant is issued at edge M+1 at the earliest, so there is exactly one IDLE cycle between packets.
- ready_o is combinational from valid_i, fifo_full_i and the registered grant. No combinational path runs from req_i to any output.
- Async reset asserted mid-packet: all outputs return to reset values immediately. A partial packet may remain in the FIFO; a downstream flush is the system's responsibility.

## Structure
- Package down_fifo_pkg holds:
  - State enum {IDLE, XFER}.
  - PKT_CNT_W = 16.
  - Widths derived from MAX_PKT and TIMEOUT via $clog2.
- Sub-module down_fifo_rr_pick: combinational round-robin picker. Inputs are the request vector and pointer; outputs are a one-hot grant and a found flag.

## Test plan
- Single packet from requester 0 of 4 words (0x11..0x14, last on 0x14), FIFO never full -> four fifo_wr_o pulses with data 0x11..0x14 in consecutive cycles, one cycle after each accept; pkt_cnt_o = 1; grant_o = 0 after the last beat.
- Requesters 0 and 1 both request continuously with 3-word packets -> grants alternate 0,1,0,1 with one IDLE cycle between packets; pkt_cnt_o = 4 after four packets.
- fifo_full_i held high for 10 cycles mid-packet -> ready_o = 0 and no fifo_wr_o during those cycles; err_timeout_o stays 0; transfer resumes without data loss or duplication.
- Granted requester drops valid_i for TIMEOUT cycles after 2 words -> err_timeout_o = 1; grant moves to the other pending requester; pkt_cnt_o unchanged; clear_err_i then returns the flag to 0.
- MAX_PKT+2 words with no last_i -> packet ends at word MAX_PKT; err_overlen_o = 1; remaining 2 words go as a new packet after re-arbitration; pkt_cnt_o = 2 once that packet ends with last_i.
- reset_n_i pulsed low mid-packet -> all outputs 0 immediately; after release, requester 0 wins first arbitration.
